// File: rtl/uart_rx_cfg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : uart_rx_cfg
//  Description : Configurable oversampling UART receiver with majority-vote
//                bit resolution, optional even/odd parity, one or two stop
//                bits, break detection and a first-word fall-through receive
//                FIFO carrying {parity_err, framing_err, data} per entry.
//  Ports       : clk, rst (async, active high)
//                uart_rxd            - serial line, idle high (asynchronous)
//                uart_mode[1:0]      - 00/11 none, 01 even, 10 odd parity
//                uart_stop2          - 0: one stop bit, 1: two stop bits
//                uart_rd_data/err    - FIFO head character and flags
//                uart_rd_valid/ready - FIFO head handshake
//                uart_overrun(_clr)  - sticky drop flag and its clear
//                fifo_count          - occupied FIFO entries
//                uart_ready          - receiver out of reset
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_cfg #(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD_RATE  = 115200,
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          uart_rxd,
    input  logic [1:0]                    uart_mode,
    input  logic                          uart_stop2,
    output logic [DATA_BITS-1:0]          uart_rd_data,
    output logic [1:0]                    uart_rd_err,
    output logic                          uart_rd_valid,
    input  logic                          uart_rd_ready,
    output logic                          uart_overrun,
    input  logic                          uart_overrun_clr,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          uart_ready
);

    localparam int c_div_raw = (CLK_FREQ + (BAUD_RATE * OVERSAMPLE) / 2) / (BAUD_RATE * OVERSAMPLE);
    localparam int c_divisor = (c_div_raw < 1) ? 1 : c_div_raw;
    localparam int c_div_w   = $clog2(c_divisor + 1);
    localparam int c_os_w    = $clog2(OVERSAMPLE);
    localparam int c_bc_w    = $clog2(DATA_BITS);
    localparam int c_aw      = $clog2(FIFO_DEPTH);
    localparam int c_ww      = DATA_BITS + 2;

    localparam logic [c_os_w-1:0] c_idx_lo   = c_os_w'(OVERSAMPLE / 2 - 1);
    localparam logic [c_os_w-1:0] c_idx_mid  = c_os_w'(OVERSAMPLE / 2);
    localparam logic [c_os_w-1:0] c_idx_hi   = c_os_w'(OVERSAMPLE / 2 + 1);
    localparam logic [c_os_w-1:0] c_idx_last = c_os_w'(OVERSAMPLE - 1);

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_start  = 3'd1;
    localparam logic [2:0] c_st_data   = 3'd2;
    localparam logic [2:0] c_st_parity = 3'd3;
    localparam logic [2:0] c_st_stop1  = 3'd4;
    localparam logic [2:0] c_st_stop2  = 3'd5;
    localparam logic [2:0] c_st_break  = 3'd6;

    logic                  r_sync1, r_sync2, r_rx_prev;
    logic [c_div_w-1:0]    r_div_cnt;
    logic [c_os_w-1:0]     r_os_cnt;
    logic [c_os_w-1:0]     r_idle_cnt;
    logic [1:0]            r_samp;
    logic [2:0]            r_state;
    logic                  r_armed;
    logic [1:0]            r_mode;
    logic                  r_stop2;
    logic [c_bc_w-1:0]     r_bit_cnt;
    logic [DATA_BITS-1:0]  r_shift;
    logic                  r_fe, r_pe;
    logic                  r_wr_en;
    logic [c_ww-1:0]       r_wr_word;
    logic                  r_ready;

    logic [c_ww-1:0]       r_mem [FIFO_DEPTH];
    logic [c_aw-1:0]       r_wr_ptr, r_rd_ptr;
    logic [c_aw:0]         r_count;
    logic                  r_overrun;

    logic w_fall, w_start, w_tick, w_resolve, w_maj, w_par_en;
    logic w_frame_end, w_fe_final, w_full, w_pop, w_push;
    logic [c_ww-1:0] w_head;

    // Two-flop synchronizer plus one history flop for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync1   <= uart_rxd;
            r_sync2   <= r_sync1;
            r_rx_prev <= r_sync2;
        end
    end

    assign w_fall  = r_rx_prev & ~r_sync2;
    assign w_start = (r_state == c_st_idle) & r_armed & w_fall;
    assign w_tick  = (r_div_cnt == c_div_w'(c_divisor - 1));

    // Tick counter restarts at the start edge so the bit grid aligns to it.
    // r_os_cnt holds the in-bit index of the next tick; the edge itself is index 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div_cnt <= '0;
            r_os_cnt  <= '0;
        end else begin
            if (w_start || w_tick) r_div_cnt <= '0;
            else                   r_div_cnt <= r_div_cnt + 1'b1;
            if (w_start)           r_os_cnt <= c_os_w'(1);
            else if (w_tick)       r_os_cnt <= (r_os_cnt == c_idx_last) ? '0 : r_os_cnt + 1'b1;
        end
    end

    // Third vote is taken live from the synchronizer on the resolving tick.
    assign w_maj     = (r_samp[1] & r_samp[0]) | (r_samp[1] & r_sync2) | (r_samp[0] & r_sync2);
    assign w_resolve = w_tick & (r_os_cnt == c_idx_hi) &
                       (r_state != c_st_idle) & (r_state != c_st_break);
    assign w_par_en  = r_mode[0] ^ r_mode[1];
    assign w_frame_end = w_resolve & (((r_state == c_st_stop1) & ~r_stop2) | (r_state == c_st_stop2));
    assign w_fe_final  = ((r_state == c_st_stop2) & r_fe) | ~w_maj;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_st_idle;
            r_samp     <= 2'b11;
            r_armed    <= 1'b0;
            r_idle_cnt <= '0;
            r_mode     <= 2'b00;
            r_stop2    <= 1'b0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_fe       <= 1'b0;
            r_pe       <= 1'b0;
            r_wr_en    <= 1'b0;
            r_wr_word  <= '0;
            r_ready    <= 1'b0;
        end else begin
            r_ready <= 1'b1;
            r_wr_en <= w_frame_end;
            if (w_frame_end) r_wr_word <= {r_pe, w_fe_final, r_shift};

            // A start is accepted only after a full bit time of idle-high line,
            // so a frame interrupted by reset cannot be picked up mid-way.
            if (!r_sync2) begin
                r_idle_cnt <= '0;
            end else if (w_tick && !r_armed) begin
                if (r_idle_cnt == c_idx_last) r_armed <= 1'b1;
                r_idle_cnt <= r_idle_cnt + 1'b1;
            end

            if (w_tick && (r_os_cnt == c_idx_lo || r_os_cnt == c_idx_mid))
                r_samp <= {r_samp[0], r_sync2};

            case (r_state)
                c_st_idle: begin
                    if (w_start) begin
                        r_state   <= c_st_start;
                        r_mode    <= uart_mode;
                        r_stop2   <= uart_stop2;
                        r_fe      <= 1'b0;
                        r_pe      <= 1'b0;
                        r_bit_cnt <= '0;
                    end
                end
                c_st_start: begin
                    if (w_resolve) r_state <= w_maj ? c_st_idle : c_st_data;
                end
                c_st_data: begin
                    if (w_resolve) begin
                        r_shift <= {w_maj, r_shift[DATA_BITS-1:1]};
                        if (r_bit_cnt == c_bc_w'(DATA_BITS - 1)) begin
                            r_bit_cnt <= '0;
                            r_state   <= w_par_en ? c_st_parity : c_st_stop1;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end
                c_st_parity: begin
                    // Odd mode (10) expects the inverse of the data XOR.
                    if (w_resolve) begin
                        r_pe    <= w_maj ^ (^r_shift) ^ r_mode[1];
                        r_state <= c_st_stop1;
                    end
                end
                c_st_stop1, c_st_stop2: begin
                    if (w_resolve) begin
                        if (r_state == c_st_stop1 && r_stop2) begin
                            r_fe    <= ~w_maj;
                            r_state <= c_st_stop2;
                        end else if (w_fe_final && (r_shift == '0) && !r_sync2) begin
                            r_state <= c_st_break;
                        end else begin
                            r_state <= c_st_idle;
                        end
                    end
                end
                c_st_break: begin
                    if (r_sync2) r_state <= c_st_idle;
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    // Receive FIFO: a full FIFO still accepts a write when the head pops in
    // the same cycle, since the slot being written is the one being freed.
    assign w_full = (r_count == (c_aw + 1)'(FIFO_DEPTH));
    assign w_pop  = uart_rd_valid & uart_rd_ready;
    assign w_push = r_wr_en & (~w_full | w_pop);

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= r_wr_word;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;
            if (r_wr_en && w_full && !w_pop) r_overrun <= 1'b1;
            else if (uart_overrun_clr)       r_overrun <= 1'b0;
        end
    end

    assign w_head        = r_mem[r_rd_ptr];
    assign uart_rd_valid = (r_count != '0);
    assign uart_rd_data  = uart_rd_valid ? w_head[DATA_BITS-1:0] : '0;
    assign uart_rd_err   = uart_rd_valid ? w_head[c_ww-1:DATA_BITS] : 2'b00;
    assign uart_overrun  = r_overrun;
    assign fifo_count    = r_count;
    assign uart_ready    = r_ready;

endmodule
`default_nettype wire
